xor_rot_cipher_core: RTL and testbench

Parametrised iterative block-cipher core, the multi-round successor to the single-XOR crypto accelerator in the crypto datapath. It accepts one DATA_W-bit block plus key and mode over a valid/ready handshake. It runs ROUNDS XOR/rotate rounds with a per-round key schedule, one round per cycle, and presents the result on a valid/ready output port. Encrypt and decrypt are true inverses. A data value of zero has no special treatment.

---
 rtl/xor_rot_cipher_core.sv | 142 ++++++++++++++
 tb/tb_xor_rot_cipher_core.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/xor_rot_cipher_core.sv
// xor_rot_cipher_core: iterative XOR/rotate block cipher.
// Accepts one block over a valid/ready handshake, runs ROUNDS rounds
// (one per cycle) with a rotated-key schedule, then holds the result on a
// valid/ready output port until the consumer takes it.
module xor_rot_cipher_core #(
  parameter int DATA_W = 32,
  parameter int ROUNDS = 4,
  parameter int ROT    = 3,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] data_in,
  input  logic [DATA_W-1:0] key,
  input  logic              encrypt,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] data_out,
  output logic              busy,
  output logic [CNT_W-1:0]  blk_count
);

  localparam int unsigned DW_U  = DATA_W;
  localparam int unsigned ROT_U = ROT;
  localparam int          RND_W = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;
  localparam logic [RND_W-1:0] LAST_RND = RND_W'(ROUNDS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    OUT  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [DATA_W-1:0] x_q;
  logic [DATA_W-1:0] key_q;
  logic              mode_q;
  logic [RND_W-1:0]  rnd_q;

  logic              accept;
  logic              out_hs;
  logic              last_rnd;
  logic [DATA_W-1:0] rk;
  logic [DATA_W-1:0] round_res;

  // Circular left rotate by any amount; the doubled word makes the wrap free.
  function automatic logic [DATA_W-1:0] rotl(input logic [DATA_W-1:0] v,
                                             input int unsigned s);
    logic [2*DATA_W-1:0] t;
    t = {v, v} << (s % DW_U);
    return t[2*DATA_W-1:DATA_W];
  endfunction

  // Circular right rotate expressed as the complementary left rotate.
  function automatic logic [DATA_W-1:0] rotr(input logic [DATA_W-1:0] v,
                                             input int unsigned s);
    return rotl(v, (DW_U - (s % DW_U)) % DW_U);
  endfunction

  assign accept   = (state_q == IDLE) && in_valid && in_ready;
  assign out_hs   = (state_q == OUT) && out_valid && out_ready;
  assign last_rnd = mode_q ? (rnd_q == LAST_RND) : (rnd_q == '0);

  // Round key and one round of the cipher for the current counter value.
  assign rk        = rotl(key_q, 32'(rnd_q)) ^ DATA_W'(rnd_q);
  assign round_res = mode_q ? rotl(x_q ^ rk, ROT_U) : (rotr(x_q, ROT_U) ^ rk);

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept)   state_d = RUN;
      RUN:     if (last_rnd) state_d = OUT;
      OUT:     if (out_hs)   state_d = IDLE;
      default:               state_d = IDLE;
    endcase
  end

  // Handshake flags, result register and completion counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      data_out  <= '0;
      blk_count <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end else begin
            in_ready <= 1'b1;
          end
        end
        RUN: begin
          if (last_rnd) begin
            data_out  <= round_res;
            out_valid <= 1'b1;
          end
        end
        OUT: begin
          if (out_hs) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
            blk_count <= blk_count + CNT_W'(1);
          end
        end
        default: begin
          in_ready  <= 1'b0;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

  // Working block, key, mode and round counter; loaded only at accept.
  always_ff @(posedge clk) begin
    if (accept) begin
      x_q    <= data_in;
      key_q  <= key;
      mode_q <= encrypt;
      rnd_q  <= encrypt ? '0 : LAST_RND;
    end else if (state_q == RUN) begin
      x_q   <= round_res;
      rnd_q <= mode_q ? (rnd_q + RND_W'(1)) : (rnd_q - RND_W'(1));
    end
  end

endmodule

// File: tb/tb_xor_rot_cipher_core.sv
// Bench for xor_rot_cipher_core: three instances (8-bit/1 round,
// 8-bit/2 rounds, 32-bit/4 rounds with a 4-bit counter) driven from one clock.
module tb_xor_rot_cipher_core;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n_ab, rst_n_c;
  logic [2:0] iv, enc, ordy;
  logic [2:0] ir, ov, bsy;
  logic [7:0]  din_a, key_a, dout_a;
  logic [7:0]  din_b, key_b, dout_b;
  logic [31:0] din_c, key_c, dout_c;
  logic [15:0] cnt_a, cnt_b;
  logic [3:0]  cnt_c;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  xor_rot_cipher_core #(.DATA_W(8), .ROUNDS(1), .ROT(1), .CNT_W(16)) u_a (
    .clk(clk), .rst_n(rst_n_ab), .in_valid(iv[0]), .in_ready(ir[0]),
    .data_in(din_a), .key(key_a), .encrypt(enc[0]), .out_valid(ov[0]),
    .out_ready(ordy[0]), .data_out(dout_a), .busy(bsy[0]), .blk_count(cnt_a));

  xor_rot_cipher_core #(.DATA_W(8), .ROUNDS(2), .ROT(1), .CNT_W(16)) u_b (
    .clk(clk), .rst_n(rst_n_ab), .in_valid(iv[1]), .in_ready(ir[1]),
    .data_in(din_b), .key(key_b), .encrypt(enc[1]), .out_valid(ov[1]),
    .out_ready(ordy[1]), .data_out(dout_b), .busy(bsy[1]), .blk_count(cnt_b));

  xor_rot_cipher_core #(.DATA_W(32), .ROUNDS(4), .ROT(3), .CNT_W(4)) u_c (
    .clk(clk), .rst_n(rst_n_c), .in_valid(iv[2]), .in_ready(ir[2]),
    .data_in(din_c), .key(key_c), .encrypt(enc[2]), .out_valid(ov[2]),
    .out_ready(ordy[2]), .data_out(dout_c), .busy(bsy[2]), .blk_count(cnt_c));

  // Reference model: cipher rules applied with plain shifts on a wide integer.
  function automatic longint unsigned rotl_m(longint unsigned x, int s, int w);
    longint unsigned mask = (64'd1 << w) - 64'd1;
    int sh = s % w;
    if (sh == 0) return x & mask;
    return ((x << sh) | (x >> (w - sh))) & mask;
  endfunction

  function automatic logic [31:0] ref_cipher(int w, int nr, int rot,
                                             logic [31:0] d, logic [31:0] k,
                                             logic e);
    longint unsigned mask = (64'd1 << w) - 64'd1;
    longint unsigned x    = 64'(d) & mask;
    longint unsigned kk   = 64'(k) & mask;
    longint unsigned rk;
    if (e) begin
      for (int r = 0; r < nr; r++) begin
        rk = rotl_m(kk, r, w) ^ (64'(r) & mask);
        x  = rotl_m(x ^ rk, rot, w);
      end
    end else begin
      for (int r = nr - 1; r >= 0; r--) begin
        rk = rotl_m(kk, r, w) ^ (64'(r) & mask);
        x  = rotl_m(x, w - (rot % w), w) ^ rk;
      end
    end
    return 32'(x);
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic set_in(input int i, input logic [31:0] d, input logic [31:0] k);
    case (i)
      0:       begin din_a = d[7:0]; key_a = k[7:0]; end
      1:       begin din_b = d[7:0]; key_b = k[7:0]; end
      default: begin din_c = d;      key_c = k;      end
    endcase
  endtask

  function automatic logic [31:0] get_out(input int i);
    case (i)
      0:       return {24'h0, dout_a};
      1:       return {24'h0, dout_b};
      default: return dout_c;
    endcase
  endfunction

  function automatic logic [31:0] get_cnt(input int i);
    case (i)
      0:       return {16'h0, cnt_a};
      1:       return {16'h0, cnt_b};
      default: return {28'h0, cnt_c};
    endcase
  endfunction

  // One full transaction; entered and left just after a falling edge.
  task automatic run_block(input int i, input logic [31:0] d, input logic [31:0] k,
                           input logic e, output logic [31:0] res,
                           output int lat, output int acc);
    int guard = 0;
    res = '0; lat = -1; acc = -1;
    while (!ir[i] && guard < 50) begin @(negedge clk); guard++; end
    if (!ir[i]) begin check("in_ready_wait", 32'd0, 32'd1); return; end
    set_in(i, d, k);
    enc[i] = e;
    iv[i]  = 1'b1;
    @(posedge clk); @(negedge clk);
    iv[i] = 1'b0;
    acc   = cyc;
    check("busy_after_accept", 32'(bsy[i]), 32'd1);
    lat = 0;
    while (!ov[i] && lat < 64) begin @(posedge clk); @(negedge clk); lat++; end
    if (!ov[i]) begin check("out_valid_wait", 32'd0, 32'd1); return; end
    res     = get_out(i);
    ordy[i] = 1'b1;
    @(posedge clk); @(negedge clk);
    ordy[i] = 1'b0;
    check("busy_after_done", 32'(bsy[i]), 32'd0);
  endtask

  typedef struct {
    int          inst;
    logic [31:0] d;
    logic [31:0] k;
    logic        e;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  function automatic vec_t mk(int inst, logic [31:0] d, logic [31:0] k,
                              logic e, logic [31:0] exp, int lat);
    vec_t v;
    v.inst = inst; v.d = d; v.k = k; v.e = e; v.exp = exp; v.lat = lat;
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs [8];
    logic [31:0] res, held, d0, k0, exp0, cb, pt;
    logic [3:0]  cnt0;
    int          lat, acc, prev_acc, guard;
    logic [31:0] rd, rk;

    vecs[0] = mk(0, 32'hA5, 32'h3C, 1'b1, 32'h33, 1);
    vecs[1] = mk(0, 32'h33, 32'h3C, 1'b0, 32'hA5, 1);
    vecs[2] = mk(1, 32'hA5, 32'h3C, 1'b1, 32'h94, 2);
    vecs[3] = mk(1, 32'h94, 32'h3C, 1'b0, 32'hA5, 2);
    vecs[4] = mk(1, 32'h00, 32'h00, 1'b1, 32'h02, 2);
    rd = $urandom; rk = $urandom;
    vecs[5] = mk(2, rd, rk, 1'b1, ref_cipher(32, 4, 3, rd, rk, 1'b1), 4);
    vecs[6] = mk(2, rd, rk, 1'b0, ref_cipher(32, 4, 3, rd, rk, 1'b0), 4);
    vecs[7] = mk(2, 32'h0, 32'h0, 1'b1, ref_cipher(32, 4, 3, 32'h0, 32'h0, 1'b1), 4);

    rst_n_ab = 1'b0; rst_n_c = 1'b0;
    iv = '0; enc = '0; ordy = '0;
    din_a = '0; key_a = '0; din_b = '0; key_b = '0; din_c = '0; key_c = '0;

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 32'(ir), 32'd0);
    check("rst_out_valid", 32'(ov), 32'd0);
    check("rst_busy", 32'(bsy), 32'd0);
    check("rst_data_out", dout_c, 32'd0);
    check("rst_count", 32'(cnt_c), 32'd0);
    rst_n_ab = 1'b1; rst_n_c = 1'b1;
    @(posedge clk); @(negedge clk);
    check("rst_release_in_ready", 32'(ir), 32'd7);

    // Table-driven vectors.
    for (int n = 0; n < 8; n++) begin
      cb = get_cnt(vecs[n].inst);
      run_block(vecs[n].inst, vecs[n].d, vecs[n].k, vecs[n].e, res, lat, acc);
      check($sformatf("vec%0d_data", n), res, vecs[n].exp);
      check($sformatf("vec%0d_latency", n), 32'(lat), 32'(vecs[n].lat));
      check($sformatf("vec%0d_count", n), get_cnt(vecs[n].inst),
            (vecs[n].inst == 2) ? ((cb + 32'd1) & 32'hF) : (cb + 32'd1));
    end

    // Backpressure with in-flight input changes.
    d0 = $urandom; k0 = $urandom;
    exp0 = ref_cipher(32, 4, 3, d0, k0, 1'b1);
    guard = 0;
    while (!ir[2] && guard < 50) begin @(negedge clk); guard++; end
    set_in(2, d0, k0); enc[2] = 1'b1; iv[2] = 1'b1;
    @(posedge clk); @(negedge clk);
    set_in(2, $urandom, $urandom); enc[2] = 1'b0;
    guard = 0;
    while (!ov[2] && guard < 20) begin @(posedge clk); @(negedge clk); guard++; end
    check("bp_result", dout_c, exp0);
    held = dout_c; cnt0 = cnt_c;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); @(negedge clk);
      check("bp_hold_data", dout_c, held);
      check("bp_hold_valid", 32'(ov[2]), 32'd1);
      check("bp_in_ready_low", 32'(ir[2]), 32'd0);
    end
    iv[2] = 1'b0; ordy[2] = 1'b1;
    @(posedge clk); @(negedge clk);
    ordy[2] = 1'b0;
    check("bp_count_step", 32'(cnt_c), 32'(4'(cnt0 + 4'd1)));
    check("bp_valid_clear", 32'(ov[2]), 32'd0);
    check("bp_in_ready_back", 32'(ir[2]), 32'd1);

    // Reset during RUN aborts the block.
    set_in(2, 32'h12345678, 32'hCAFEF00D); enc[2] = 1'b1; iv[2] = 1'b1;
    @(posedge clk); @(negedge clk);
    iv[2] = 1'b0;
    @(posedge clk); @(negedge clk);
    rst_n_c = 1'b0;
    @(posedge clk); @(negedge clk);
    check("midrst_out_valid", 32'(ov[2]), 32'd0);
    check("midrst_busy", 32'(bsy[2]), 32'd0);
    check("midrst_data_out", dout_c, 32'd0);
    check("midrst_count", 32'(cnt_c), 32'd0);
    check("midrst_in_ready", 32'(ir[2]), 32'd0);
    rst_n_c = 1'b1;
    @(posedge clk); @(negedge clk);
    check("midrst_in_ready_back", 32'(ir[2]), 32'd1);
    check("midrst_no_output", 32'(ov[2]), 32'd0);
    run_block(2, 32'hA5, 32'h3C, 1'b1, res, lat, acc);
    check("post_rst_data", res, ref_cipher(32, 4, 3, 32'hA5, 32'h3C, 1'b1));
    check("post_rst_count", 32'(cnt_c), 32'd1);

    // Clean reset, then random round trips at full throughput.
    rst_n_c = 1'b0;
    @(posedge clk); @(negedge clk);
    rst_n_c = 1'b1;
    @(posedge clk); @(negedge clk);
    prev_acc = -1;
    for (int p = 0; p < 20; p++) begin
      d0 = $urandom; k0 = $urandom;
      for (int h = 0; h < 2; h++) begin
        if (h == 0) run_block(2, d0, k0, 1'b1, cb, lat, acc);
        else        run_block(2, cb, k0, 1'b0, pt, lat, acc);
        check("rnd_latency", 32'(lat), 32'd4);
        if (prev_acc >= 0) begin
          total++;
          if (acc - prev_acc < 6) begin
            bad++;
            $display("FAIL accept_spacing: got %0d want >= 6", acc - prev_acc);
          end
        end
        prev_acc = acc;
      end
      check("rnd_cipher", cb, ref_cipher(32, 4, 3, d0, k0, 1'b1));
      check("rnd_roundtrip", pt, d0);
    end
    check("rnd_count_wrap", 32'(cnt_c), 32'd8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
